ifetch_unit: RTL

Instruction-fetch initiator that drives the instruction ROM in the pipelined MIPS core. It owns the PC, issues word addresses to the ROM and captures the returned instruction words. Results are buffered in a 2-entry skid FIFO and presented to the IF/ID stage with a valid/ready handshake. It also accepts branch/jump redirects, which flush everything in flight.

---
 rtl/ifetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch initiator for the pipelined MIPS core.
//   Owns the fetch PC, issues word addresses to a one-cycle-latency ROM,
//   captures returned words into a 2-entry skid FIFO and hands them to the
//   IF/ID stage over a valid/ready handshake. Redirects flush everything
//   in flight; reset has priority over redirect, redirect over pop.
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   rom_adr        ROM word index (fetch_pc >> 2), registered
//   rom_dout       ROM read data, valid the cycle after rom_adr is sampled
//   redirect_valid branch/jump taken: flush and refetch
//   redirect_pc    redirect byte address (bits [1:0] ignored)
//   id_ready       decode stage accepts the head entry
//   id_valid       head entry valid
//   id_instr       instruction at head
//   id_pc          byte PC of id_instr
//   id_pc_plus4    id_pc + 4
module ifetch_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_adr,
  input  logic [DATA_W-1:0] rom_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4
);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_rom_adr;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic [DATA_W-1:0] r_instr [2];
  logic [ADDR_W-1:0] r_pc    [2];
  logic              r_head;
  logic [1:0]        r_count;

  logic              w_has;
  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_wr_idx;
  logic [2:0]        w_occ;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] w_redirect_pc;

  assign w_has   = (r_count != 2'd0);
  assign w_valid = w_has && !redirect_valid;
  assign w_pop   = w_valid && id_ready;

  // Issue only if the word can be stored: buffered + in flight - leaving < 2.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_issue = (w_occ < (3'd2 + {2'b00, w_pop}));

  // Tail slot is head + count (mod 2). With count==2 a push only happens
  // alongside a pop, so it lands in the slot being freed.
  assign w_wr_idx = r_head ^ r_count[0];

  assign w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
  assign w_redirect_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rom_adr     <= RESET_PC >> 2;
      r_inflight_pc <= RESET_PC;
      r_inflight    <= 1'b0;
      r_head        <= 1'b0;
      r_count       <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      r_rom_adr  <= redirect_pc >> 2;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= w_fetch_pc_nxt;
        r_rom_adr     <= w_fetch_pc_nxt >> 2;
        r_inflight    <= 1'b1;
      end else begin
        r_inflight <= 1'b0;
      end

      if (r_inflight) begin
        r_instr[w_wr_idx] <= rom_dout;
        r_pc[w_wr_idx]    <= r_inflight_pc;
      end

      if (w_pop) begin
        r_head <= ~r_head;
      end

      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rom_adr     = r_rom_adr;
  assign id_valid    = w_valid;
  assign id_instr    = w_has ? r_instr[r_head] : '0;
  assign id_pc       = w_has ? r_pc[r_head] : '0;
  assign id_pc_plus4 = w_has ? (r_pc[r_head] + ADDR_W'(4)) : '0;

endmodule
